rls_sequencer: RTL and testbench

RLS_SEQUENCER -- requirements
Module: rls_sequencer

---
 rtl/rls_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_rls_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rls_sequencer.sv
// rls_sequencer: control sequencer for a block-based RLS adaptive filter.
// Each block clears the datapath and then runs M iterations. One iteration is
// a coefficient load, an N-beat S computation, a wait for a measurement, an
// R update and an N-beat X update. After the last iteration the block counter
// advances and N coefficient beats are written out through a ready-qualified
// sink. The run ends after B blocks; B = 0 means the run never ends.
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   start_i, abort_i     begin a run from IDLE/DONE; synchronous abort to IDLE
//   meas_valid_i/ready_o measurement handshake, accepted only in WAITM
//   wr_ready_i           coefficient sink can accept a beat
//   load_o .. write_o    datapath strobes, decoded from state and beat counter
//   busy_o, final_o      run active / run complete
//   iterations_o         iteration count within the current block
//   blocks_o             number of completed blocks
module rls_sequencer #(
    parameter int N  = 16,
    parameter int M  = 20,
    parameter int B  = 1024,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          meas_valid_i,
    output logic          meas_ready_o,
    input  logic          wr_ready_i,
    output logic          load_o,
    output logic          loadx_o,
    output logic          clears_o,
    output logic          clear_o,
    output logic          sha_o,
    output logic          shx0_o,
    output logic          s1_o,
    output logic          s2_o,
    output logic          enmult_o,
    output logic          enadder_o,
    output logic          ens_o,
    output logic          shx_o,
    output logic          shk_o,
    output logic          encounter_o,
    output logic          write_o,
    output logic          busy_o,
    output logic          final_o,
    output logic [CW-1:0] iterations_o,
    output logic [CW-1:0] blocks_o
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] NEWSYS   = 4'd1;
    localparam logic [3:0] NEWIT    = 4'd2;
    localparam logic [3:0] CALCS    = 4'd3;
    localparam logic [3:0] WAITM    = 4'd4;
    localparam logic [3:0] CALCR    = 4'd5;
    localparam logic [3:0] CALCX    = 4'd6;
    localparam logic [3:0] COUNTSYS = 4'd7;
    localparam logic [3:0] SAVEX    = 4'd8;
    localparam logic [3:0] DONE     = 4'd9;

    // Beat counter is sized from N alone so a narrow CW cannot truncate it.
    localparam int          BW      = $clog2(N + 1);
    localparam logic [BW-1:0] LAST  = BW'(N - 1);
    localparam logic [CW-1:0] M_C   = CW'(M);
    localparam logic [CW-1:0] B_C   = CW'(B);

    logic [3:0]    state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [CW-1:0] iter_q, iter_d;
    logic [CW-1:0] blk_q, blk_d;
    logic          beat_last;

    assign beat_last = (beat_q == LAST);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        iter_d  = iter_q;
        blk_d   = blk_q;
        if (abort_i) begin
            state_d = IDLE;
            beat_d  = '0;
            iter_d  = '0;
            blk_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start_i) begin
                    state_d = NEWSYS;
                    blk_d   = '0;
                end
                NEWSYS: begin
                    state_d = NEWIT;
                    iter_d  = '0;
                end
                NEWIT: begin
                    state_d = CALCS;
                    beat_d  = '0;
                end
                CALCS: begin
                    if (beat_last) begin
                        state_d = WAITM;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
                WAITM: if (meas_valid_i) state_d = CALCR;
                CALCR: begin
                    state_d = CALCX;
                    beat_d  = '0;
                    iter_d  = iter_q + CW'(1);
                end
                CALCX: begin
                    if (beat_last) begin
                        state_d = (iter_q == M_C) ? COUNTSYS : NEWIT;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
                COUNTSYS: begin
                    state_d = SAVEX;
                    beat_d  = '0;
                    blk_d   = blk_q + CW'(1);
                end
                SAVEX: if (wr_ready_i) begin
                    // Only accepted beats advance; a stalled sink holds the beat.
                    if (beat_last) begin
                        beat_d  = '0;
                        state_d = (B != 0 && blk_q == B_C) ? DONE : NEWSYS;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            iter_q  <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            iter_q  <= iter_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        load_o       = 1'b0;
        loadx_o      = 1'b0;
        clears_o     = 1'b0;
        clear_o      = 1'b0;
        sha_o        = 1'b0;
        shx0_o       = 1'b0;
        s1_o         = 1'b0;
        s2_o         = 1'b0;
        enmult_o     = 1'b0;
        enadder_o    = 1'b0;
        ens_o        = 1'b0;
        shx_o        = 1'b0;
        shk_o        = 1'b0;
        encounter_o  = 1'b0;
        write_o      = 1'b0;
        meas_ready_o = 1'b0;
        busy_o       = (state_q != IDLE) && (state_q != DONE);
        final_o      = (state_q == DONE);
        case (state_q)
            NEWSYS: clear_o = 1'b1;
            NEWIT: begin
                load_o   = 1'b1;
                loadx_o  = 1'b1;
                clears_o = 1'b1;
            end
            CALCS: begin
                sha_o     = 1'b1;
                shx0_o    = 1'b1;
                enmult_o  = 1'b1;
                enadder_o = 1'b1;
                ens_o     = 1'b1;
            end
            WAITM: meas_ready_o = 1'b1;
            CALCR: begin
                shx0_o      = 1'b1;
                encounter_o = 1'b1;
            end
            CALCX: begin
                s1_o     = 1'b1;
                s2_o     = 1'b1;
                shx_o    = 1'b1;
                shx0_o   = 1'b1;
                enmult_o = 1'b1;
                shk_o    = !beat_last;   // K shifts on all but the final beat
            end
            SAVEX: begin
                write_o = 1'b1;
                shx_o   = wr_ready_i;
            end
            default: ;
        endcase
    end

    assign iterations_o = iter_q;
    assign blocks_o     = blk_q;

endmodule

// File: tb/tb_rls_sequencer.sv
// Directed bench for rls_sequencer with N=4, M=2. Instance dut runs with B=2,
// instance dut0 with B=0 (unbounded run). Strobes are packed into an 18-bit
// vector and compared cycle by cycle against hand-derived per-state values.
module tb_rls_sequencer;

    logic        clk, reset;
    logic        start, abort, mv, wr;
    logic        start0, abort0, mv0, wr0;
    logic [17:0] s, s0;
    logic [15:0] it, bl, it0, bl0;
    int          checks = 0;
    int          errors = 0;
    int          sc;

    // Strobe bit positions in s / s0.
    localparam logic [17:0] LOAD    = 18'd1 << 17;
    localparam logic [17:0] LOADX   = 18'd1 << 16;
    localparam logic [17:0] CLEARS  = 18'd1 << 15;
    localparam logic [17:0] CLEAR   = 18'd1 << 14;
    localparam logic [17:0] SHA     = 18'd1 << 13;
    localparam logic [17:0] SHX0    = 18'd1 << 12;
    localparam logic [17:0] S1      = 18'd1 << 11;
    localparam logic [17:0] S2      = 18'd1 << 10;
    localparam logic [17:0] ENMULT  = 18'd1 << 9;
    localparam logic [17:0] ENADDER = 18'd1 << 8;
    localparam logic [17:0] ENS     = 18'd1 << 7;
    localparam logic [17:0] SHX     = 18'd1 << 6;
    localparam logic [17:0] SHK     = 18'd1 << 5;
    localparam logic [17:0] ENCNT   = 18'd1 << 4;
    localparam logic [17:0] WRITE   = 18'd1 << 3;
    localparam logic [17:0] MRDY    = 18'd1 << 2;
    localparam logic [17:0] BUSY    = 18'd1 << 1;
    localparam logic [17:0] FINAL   = 18'd1 << 0;
    localparam logic [17:0] E_NEWSYS = BUSY | CLEAR;
    localparam logic [17:0] E_WAITM  = BUSY | MRDY;

    rls_sequencer #(.N(4), .M(2), .B(2), .CW(16)) dut (
        .clk(clk), .reset(reset), .start_i(start), .abort_i(abort),
        .meas_valid_i(mv), .meas_ready_o(s[2]), .wr_ready_i(wr),
        .load_o(s[17]), .loadx_o(s[16]), .clears_o(s[15]), .clear_o(s[14]),
        .sha_o(s[13]), .shx0_o(s[12]), .s1_o(s[11]), .s2_o(s[10]),
        .enmult_o(s[9]), .enadder_o(s[8]), .ens_o(s[7]), .shx_o(s[6]),
        .shk_o(s[5]), .encounter_o(s[4]), .write_o(s[3]),
        .busy_o(s[1]), .final_o(s[0]), .iterations_o(it), .blocks_o(bl));

    rls_sequencer #(.N(4), .M(2), .B(0), .CW(16)) dut0 (
        .clk(clk), .reset(reset), .start_i(start0), .abort_i(abort0),
        .meas_valid_i(mv0), .meas_ready_o(s0[2]), .wr_ready_i(wr0),
        .load_o(s0[17]), .loadx_o(s0[16]), .clears_o(s0[15]), .clear_o(s0[14]),
        .sha_o(s0[13]), .shx0_o(s0[12]), .s1_o(s0[11]), .s2_o(s0[10]),
        .enmult_o(s0[9]), .enadder_o(s0[8]), .ens_o(s0[7]), .shx_o(s0[6]),
        .shk_o(s0[5]), .encounter_o(s0[4]), .write_o(s0[3]),
        .busy_o(s0[1]), .final_o(s0[0]), .iterations_o(it0), .blocks_o(bl0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected strobes at offset i (0..27) of a block with N=4, M=2, no stalls:
    // NEWSYS, 2 x {NEWIT, CALCS x4, WAITM, CALCR, CALCX x4}, COUNTSYS, SAVEX x4.
    function automatic logic [17:0] exp_blk(input int i);
        int k;
        if (i == 0)  return E_NEWSYS;
        if (i == 23) return BUSY;
        if (i >= 24) return BUSY | WRITE | SHX;
        k = (i - 1) % 11;
        if (k == 0) return BUSY | LOAD | LOADX | CLEARS;
        if (k <= 4) return BUSY | SHA | SHX0 | ENMULT | ENADDER | ENS;
        if (k == 5) return E_WAITM;
        if (k == 6) return BUSY | SHX0 | ENCNT;
        return BUSY | S1 | S2 | SHX | SHX0 | ENMULT | ((k < 10) ? SHK : 18'd0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {start, abort, mv, wr} = '0;
        {start0, abort0, mv0, wr0} = '0;
        #2 reset = 1'b0;
        #1;
        chk("reset_strobes", 32'(s), 0);
        chk("reset_iter", 32'(it), 0);
        chk("reset_blocks", 32'(bl), 0);
        #19 reset = 1'b1;
        step();
        step();
        chk("idle_hold", 32'(s), 0);

        // Full run, B=2: 28 cycles per block, DONE at cycle 57.
        mv = 1'b1; wr = 1'b1; start = 1'b1; sc = 0;
        for (int i = 1; i <= 57; i++) begin
            step();
            start = 1'b0;
            if (i <= 56) begin
                chk($sformatf("run_c%0d", i), 32'(s), 32'(exp_blk((i - 1) % 28)));
                if (s[3] && s[6]) sc++;
            end else begin
                chk("run_done", 32'(s), 32'(FINAL));
            end
            if (i == 24 || i == 52) chk($sformatf("run_iter_c%0d", i), 32'(it), 2);
            if (i == 25) chk("run_blk_first", 32'(bl), 1);
        end
        chk("run_savex_shx", sc, 8);
        chk("run_blocks", 32'(bl), 2);

        // Measurement stall: WAITM held 10 cycles with meas_valid low.
        mv = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("rs_newsys", 32'(s), 32'(E_NEWSYS));
        chk("rs_blk_clr", 32'(bl), 0);
        for (int i = 1; i <= 6; i++) begin
            step();
            chk($sformatf("wm_c%0d", i), 32'(s), 32'(exp_blk(i)));
        end
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("wm_hold%0d", i), 32'(s), 32'(E_WAITM));
            chk($sformatf("wm_iter%0d", i), 32'(it), 0);
        end
        mv = 1'b1;
        step();
        chk("wm_calcr", 32'(s), 32'(exp_blk(7)));
        step();
        chk("wm_calcx1", 32'(s), 32'(exp_blk(8)));
        chk("wm_iter1", 32'(it), 1);
        step();
        chk("wm_calcx2", 32'(s), 32'(exp_blk(9)));

        // Abort during CALCX cycle 2.
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_strobes", 32'(s), 0);
        chk("ab_iter", 32'(it), 0);
        chk("ab_blocks", 32'(bl), 0);
        step();
        chk("ab_idle", 32'(s), 0);

        // Clean restart, sink stalls 3 cycles at SAVEX beat 2.
        start = 1'b1; sc = 0;
        for (int i = 0; i <= 25; i++) begin
            step();
            start = 1'b0;
            chk($sformatf("st_c%0d", i), 32'(s), 32'(exp_blk(i)));
            if (s[3] && s[6]) sc++;
        end
        step();
        wr = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) step();
            chk($sformatf("st_stall%0d", j), 32'(s), 32'(BUSY | WRITE));
        end
        wr = 1'b1;
        #1;
        chk("st_beat2", 32'(s), 32'(exp_blk(26)));
        if (s[3] && s[6]) sc++;
        step();
        chk("st_beat3", 32'(s), 32'(exp_blk(27)));
        if (s[3] && s[6]) sc++;
        step();
        chk("st_newsys", 32'(s), 32'(E_NEWSYS));
        chk("st_blocks", 32'(bl), 1);
        chk("st_shx_cnt", sc, 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("st_ab_strobes", 32'(s), 0);
        chk("st_ab_blocks", 32'(bl), 0);

        // Asynchronous reset in the middle of SAVEX.
        start = 1'b1;
        for (int i = 0; i <= 25; i++) begin
            step();
            start = 1'b0;
        end
        chk("rst_pre", 32'(s), 32'(exp_blk(25)));
        #2 reset = 1'b0;
        #1;
        chk("rst_strobes", 32'(s), 0);
        chk("rst_blocks", 32'(bl), 0);
        chk("rst_iter", 32'(it), 0);
        #3 reset = 1'b1;
        mv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rst_idle%0d", i), 32'(s), 0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rst_restart", 32'(s), 32'(E_NEWSYS));
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Unbounded run (B=0): 3 full blocks plus the next NEWSYS.
        mv0 = 1'b1; wr0 = 1'b1; start0 = 1'b1;
        for (int i = 0; i <= 84; i++) begin
            step();
            start0 = 1'b0;
            chk($sformatf("inf_c%0d", i), 32'(s0), 32'(exp_blk(i % 28)));
            if (i % 28 == 0) chk($sformatf("inf_blk_c%0d", i), 32'(bl0), 32'(i / 28));
            if (i % 28 == 1) chk($sformatf("inf_iter_c%0d", i), 32'(it0), 0);
            if (i % 28 == 24) chk($sformatf("inf_inc_c%0d", i), 32'(bl0), 32'(i / 28 + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
